// File: rtl/zbt_arbiter.sv
// Shares one ZBT bank between a camera writer and a display reader. Reads win,
// writes get a bounded wait, and only every FRAME_DIV-th camera frame is stored.
module zbt_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 36,
  parameter int FRAME_DIV = 4,
  parameter int MAX_WAIT  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              zbt_cen,
  output logic              zbt_we,
  output logic [ADDR_W-1:0] zbt_addr,
  output logic [DATA_W-1:0] zbt_wdata,
  output logic              zbt_frame_enable,
  input  logic [DATA_W-1:0] zbt_rdata
);

  localparam int CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  frame_cnt;
  logic              buf_full;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        tag_pipe;
  logic              cmd_we;
  logic              store_frame;
  logic              force_wr;
  logic              rd_grant;
  logic              wr_grant;
  logic              accept;

  // Arbitration: reads win unless the buffered write has waited its limit.
  always_comb begin
    store_frame = (frame_cnt == {CNT_W{1'b0}});
    force_wr    = buf_full && (wait_cnt == WAIT_MAX);
    rd_grant    = !reset && rd_req && !force_wr;
    wr_grant    = !reset && buf_full && !rd_grant;
    wr_ready    = !reset && (!buf_full || wr_grant);
    accept      = wr_req && wr_ready;
  end

  assign rd_ack   = rd_grant;
  // cen stays high outside reset: the driver's write pipeline must never freeze.
  assign zbt_cen  = !reset;
  assign zbt_we   = cmd_we && !reset;
  assign rd_valid = tag_pipe[3] && !reset;

  // Frame decimation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= {CNT_W{1'b0}};
    end else if (frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= {CNT_W{1'b0}};
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

  // One-entry write buffer; writes accepted in skipped frames are dropped here.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_addr <= {ADDR_W{1'b0}};
      buf_data <= {DATA_W{1'b0}};
    end else if (accept && store_frame) begin
      buf_full <= 1'b1;
      buf_addr <= wr_addr;
      buf_data <= wr_data;
    end else if (wr_grant) begin
      buf_full <= 1'b0;
    end else begin
      buf_full <= buf_full;
    end
  end

  // Counts reads that beat the buffered write.
  always_ff @(posedge clk) begin
    if (reset || !buf_full || wr_grant) begin
      wait_cnt <= {WAIT_W{1'b0}};
    end else if (rd_grant && (wait_cnt != WAIT_MAX)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Register the granted command onto the driver interface.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_we           <= 1'b0;
      zbt_frame_enable <= 1'b0;
      zbt_addr         <= {ADDR_W{1'b0}};
      zbt_wdata        <= {DATA_W{1'b0}};
    end else if (wr_grant) begin
      cmd_we           <= 1'b1;
      zbt_frame_enable <= 1'b1;
      zbt_addr         <= buf_addr;
      zbt_wdata        <= buf_data;
    end else if (rd_grant) begin
      cmd_we           <= 1'b0;
      zbt_frame_enable <= 1'b0;
      zbt_addr         <= rd_addr;
      zbt_wdata        <= {DATA_W{1'b0}};
    end else begin
      cmd_we           <= 1'b0;
      zbt_frame_enable <= 1'b0;
      zbt_addr         <= {ADDR_W{1'b0}};
      zbt_wdata        <= {DATA_W{1'b0}};
    end
  end

  // Read tags follow the command, driver and capture stages; bit 3 is rd_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_pipe <= 4'b0000;
      rd_data  <= {DATA_W{1'b0}};
    end else begin
      tag_pipe <= {tag_pipe[2:0], rd_grant};
      if (tag_pipe[2]) begin
        rd_data <= zbt_rdata;
      end else begin
        rd_data <= rd_data;
      end
    end
  end

endmodule
